mem_interface: RTL and testbench

- Memory-access stage directly downstream of the multicycle CPU controller.
- Owns MAR, MDR and IR, drives the internal data bus from MAR/MDR, and runs a req/ack handshake to external memory with variable wait states.
- Returns mem_ready to the controller so it can hold its memory state until the access completes.
- Fetched instruction word is presented to the controller on ir_out.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_interface_if.sv | 39 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_interface.sv | 123 ++++++++++++
 tb/tb_mem_interface.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU memory-access stage.
package cpu_pkg;

   localparam int unsigned ADDR_W_DEF  = 12;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT,
      DONE
   } mem_state_t;

   // Wait-counter width; never zero so a TIMEOUT of 1 still yields a legal vector.
   function automatic int unsigned cnt_w(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Controller-side bus/strobe signals plus the external memory handshake.
interface mem_interface_if
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic [DATA_W-1:0] bus_in;
   logic              ldMAR;
   logic              ldMDR;
   logic              TMAR;
   logic              TMDR;
   logic              MemRead;
   logic              MemWrite;
   logic              IRWrite;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic [DATA_W-1:0] ir_out;
   logic              mem_ready;
   logic              mem_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  bus_in, ldMAR, ldMDR, TMAR, TMDR, MemRead, MemWrite, IRWrite, mem_rdata, mem_ack,
      output bus_out, bus_oe, ir_out, mem_ready, mem_err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output bus_in, ldMAR, ldMDR, TMAR, TMDR, MemRead, MemWrite, IRWrite, mem_rdata, mem_ack,
      input  bus_out, bus_oe, ir_out, mem_ready, mem_err, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Clear/enable wait-state counter; holds at terminal count instead of wrapping.
module mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic Clk,
   input  logic Reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned CW = cnt_w(TIMEOUT);

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge Clk) begin
      if (!Reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_interface.sv
// Memory-access stage: owns MAR/MDR/IR, drives the internal bus and runs the
// req/ack handshake with timeout to external memory.
module mem_interface
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   mem_interface_if.slave  mif
);

   mem_state_t        r_state;
   mem_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_mdr;
   logic [DATA_W-1:0] r_ir;
   logic              r_irw;
   logic              r_err;
   logic              r_ill;

   logic w_idle;
   logic w_wait;
   logic w_ld_ok;
   logic w_tc;
   logic w_rd_req;
   logic w_wr_req;

   assign w_idle   = (r_state == IDLE);
   assign w_wait   = (r_state == RD_WAIT) || (r_state == WR_WAIT);
   assign w_ld_ok  = (r_state == IDLE) || (r_state == DONE);
   assign w_rd_req = mif.MemRead && !mif.MemWrite;
   assign w_wr_req = mif.MemWrite && !mif.MemRead;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .Clk   (Clk),
      .Reset (Reset),
      .i_clr (!w_wait),
      .i_en  (w_wait && !mif.mem_ack),
      .o_tc  (w_tc)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      mif.mem_req   = 1'b0;
      mif.mem_we    = 1'b0;
      mif.mem_ready = r_ill;
      mif.mem_err   = r_ill;
      unique case (r_state)
         IDLE: begin
            if (w_idle && w_rd_req) begin
               w_state_nxt = RD_WAIT;
            end else if (w_idle && w_wr_req) begin
               w_state_nxt = WR_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            mif.mem_req = 1'b1;
            mif.mem_we  = (r_state == WR_WAIT);
            if (mif.mem_ack || w_tc) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            mif.mem_ready = 1'b1;
            mif.mem_err   = r_err;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_mar <= '0;
         r_mdr <= '0;
         r_ir  <= '0;
         r_irw <= 1'b0;
         r_err <= 1'b0;
         r_ill <= 1'b0;
      end else begin
         r_ill <= w_idle && mif.MemRead && mif.MemWrite;
         if (w_ld_ok && mif.ldMAR) begin
            r_mar <= mif.bus_in[ADDR_W-1:0];
         end
         if (w_ld_ok && mif.ldMDR) begin
            r_mdr <= mif.bus_in;
         end
         if (w_idle && w_rd_req) begin
            r_irw <= mif.IRWrite;
         end
         if ((r_state == RD_WAIT) && mif.mem_ack) begin
            r_mdr <= mif.mem_rdata;
            if (r_irw) begin
               r_ir <= mif.mem_rdata;
            end
         end
         // Ack wins over a simultaneous terminal count.
         if (w_wait) begin
            r_err <= !mif.mem_ack && w_tc;
         end
      end
   end

   assign mif.bus_out   = mif.TMDR ? r_mdr : (mif.TMAR ? DATA_W'(r_mar) : '0);
   assign mif.bus_oe    = mif.TMAR || mif.TMDR;
   assign mif.ir_out    = r_ir;
   assign mif.mem_addr  = r_mar;
   assign mif.mem_wdata = r_mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: bus table, directed access sequences and random
// transactions checked against a transaction-level register model.
module tb_mem_interface;
   import cpu_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 16;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   mem_interface_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   mem_interface #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .mif   (mif)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Architectural model of the three registers.
   logic [AW-1:0] exp_mar;
   logic [DW-1:0] exp_mdr;
   logic [DW-1:0] exp_ir;

   typedef struct {
      logic        ld_mar;
      logic        ld_mdr;
      logic        t_mar;
      logic        t_mdr;
      logic [15:0] bin;
      logic [15:0] exp_bus;
      logic        exp_oe;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      mif.bus_in    = '0;
      mif.ldMAR     = 1'b0;
      mif.ldMDR     = 1'b0;
      mif.TMAR      = 1'b0;
      mif.TMDR      = 1'b0;
      mif.MemRead   = 1'b0;
      mif.MemWrite  = 1'b0;
      mif.IRWrite   = 1'b0;
      mif.mem_rdata = '0;
      mif.mem_ack   = 1'b0;
   endtask

   // Called at a negedge; observes registers through the bus drivers.
   task automatic check_regs(input string tag);
      mif.TMAR = 1'b1;
      mif.TMDR = 1'b0;
      #1;
      chk({tag, "_busmar"}, mif.bus_out, DW'(exp_mar));
      chk({tag, "_addr"}, mif.mem_addr, exp_mar);
      mif.TMDR = 1'b1;
      #1;
      chk({tag, "_busmdr"}, mif.bus_out, exp_mdr);
      chk({tag, "_wdata"}, mif.mem_wdata, exp_mdr);
      mif.TMAR = 1'b0;
      mif.TMDR = 1'b0;
      #1;
      chk({tag, "_oe0"}, mif.bus_oe, 1'b0);
      chk({tag, "_ir"}, mif.ir_out, exp_ir);
   endtask

   // op: 0 read, 1 write, 2 illegal. ack_at >= TO means memory never acks.
   task automatic do_access(input string tag, input int op, input bit irw,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int ack_at, input logic [DW-1:0] rdata);
      int ncyc;
      @(negedge Clk);
      mif.bus_in = wdata;
      mif.ldMDR  = 1'b1;
      @(negedge Clk);
      mif.ldMDR  = 1'b0;
      exp_mdr    = wdata;
      mif.bus_in = DW'($urandom);
      mif.bus_in[AW-1:0] = addr;
      mif.ldMAR    = 1'b1;
      mif.MemRead  = (op != 1);
      mif.MemWrite = (op != 0);
      mif.IRWrite  = irw;
      @(negedge Clk);
      exp_mar      = addr;
      mif.ldMAR    = 1'b0;
      mif.MemRead  = 1'b0;
      mif.MemWrite = 1'b0;
      mif.IRWrite  = 1'b0;
      if (op == 2) begin
         chk({tag, "_ill_req"}, mif.mem_req, 1'b0);
         chk({tag, "_ill_ready"}, mif.mem_ready, 1'b1);
         chk({tag, "_ill_err"}, mif.mem_err, 1'b1);
         check_regs(tag);
         @(negedge Clk);
         chk({tag, "_ill_ready_drop"}, mif.mem_ready, 1'b0);
         chk({tag, "_ill_err_drop"}, mif.mem_err, 1'b0);
      end else begin
         ncyc = (ack_at < int'(TO)) ? ack_at + 1 : int'(TO);
         for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge Clk);
            chk({tag, "_req"}, mif.mem_req, 1'b1);
            chk({tag, "_we"}, mif.mem_we, (op == 1));
            chk({tag, "_addr_hold"}, mif.mem_addr, exp_mar);
            chk({tag, "_wdata_hold"}, mif.mem_wdata, exp_mdr);
            chk({tag, "_no_ready"}, mif.mem_ready, 1'b0);
            mif.mem_ack   = (i == ack_at);
            mif.mem_rdata = (i == ack_at) ? rdata : DW'($urandom);
            // Loads must be ignored while waiting.
            mif.ldMAR  = 1'b1;
            mif.ldMDR  = 1'b1;
            mif.bus_in = DW'($urandom);
         end
         @(negedge Clk);
         mif.mem_ack = 1'b0;
         mif.ldMAR   = 1'b0;
         mif.ldMDR   = 1'b0;
         chk({tag, "_done_req"}, mif.mem_req, 1'b0);
         chk({tag, "_done_ready"}, mif.mem_ready, 1'b1);
         chk({tag, "_done_err"}, mif.mem_err, (ack_at >= int'(TO)));
         if (op == 0 && ack_at < int'(TO)) begin
            exp_mdr = rdata;
            if (irw) exp_ir = rdata;
         end
         check_regs(tag);
         @(negedge Clk);
         chk({tag, "_ready_drop"}, mif.mem_ready, 1'b0);
         chk({tag, "_err_drop"}, mif.mem_err, 1'b0);
      end
   endtask

   initial begin
      int op;
      int ack_at;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hF123, 16'h0123, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0ABC, 16'hBEEF, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h5A5A, 16'h0A5A, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 1'b1};

      clear_inputs();
      exp_mar = '0;
      exp_mdr = '0;
      exp_ir  = '0;

      // Reset state.
      repeat (2) @(negedge Clk);
      chk("rst_bus_out", mif.bus_out, '0);
      chk("rst_bus_oe", mif.bus_oe, 1'b0);
      chk("rst_ir", mif.ir_out, '0);
      chk("rst_req", mif.mem_req, 1'b0);
      chk("rst_we", mif.mem_we, 1'b0);
      chk("rst_ready", mif.mem_ready, 1'b0);
      chk("rst_err", mif.mem_err, 1'b0);
      chk("rst_addr", mif.mem_addr, '0);
      chk("rst_wdata", mif.mem_wdata, '0);
      Reset = 1'b1;

      // Bus drive / register load table.
      foreach (vecs[k]) begin
         @(negedge Clk);
         mif.ldMAR  = vecs[k].ld_mar;
         mif.ldMDR  = vecs[k].ld_mdr;
         mif.TMAR   = vecs[k].t_mar;
         mif.TMDR   = vecs[k].t_mdr;
         mif.bus_in = vecs[k].bin;
         if (vecs[k].ld_mar) exp_mar = vecs[k].bin[AW-1:0];
         if (vecs[k].ld_mdr) exp_mdr = vecs[k].bin;
         @(posedge Clk);
         #1;
         mif.ldMAR = 1'b0;
         mif.ldMDR = 1'b0;
         chk($sformatf("vec%0d_bus_out", k), mif.bus_out, vecs[k].exp_bus);
         chk($sformatf("vec%0d_bus_oe", k), mif.bus_oe, vecs[k].exp_oe);
      end
      @(negedge Clk);
      clear_inputs();
      check_regs("table");

      // Directed accesses.
      do_access("fetch0", 0, 1'b1, 12'h010, 16'h1111, 0, 16'h000F);
      do_access("write3", 1, 1'b0, 12'h3FF, 16'hBEEF, 3, 16'hDEAD);
      do_access("tmo", 0, 1'b1, 12'h222, 16'hCAFE, 99, 16'h9999);
      do_access("ill", 2, 1'b0, 12'h456, 16'h0BAD, 0, 16'h0000);
      do_access("lastack", 0, 1'b1, 12'h777, 16'h3333, int'(TO) - 1, 16'h4321);
      do_access("rd_noir", 0, 1'b0, 12'h001, 16'h2222, 2, 16'h7E7E);

      // Reset in the second wait cycle, with an ack arriving at the same edge.
      @(negedge Clk);
      mif.MemRead = 1'b1;
      mif.IRWrite = 1'b1;
      @(negedge Clk);
      mif.MemRead = 1'b0;
      mif.IRWrite = 1'b0;
      chk("mid_req1", mif.mem_req, 1'b1);
      @(negedge Clk);
      chk("mid_req2", mif.mem_req, 1'b1);
      Reset         = 1'b0;
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 16'h1234;
      @(negedge Clk);
      Reset       = 1'b1;
      mif.mem_ack = 1'b0;
      exp_mar = '0;
      exp_mdr = '0;
      exp_ir  = '0;
      chk("mid_req_drop", mif.mem_req, 1'b0);
      chk("mid_no_ready", mif.mem_ready, 1'b0);
      chk("mid_no_err", mif.mem_err, 1'b0);
      check_regs("mid");
      @(negedge Clk);
      chk("mid_no_ready2", mif.mem_ready, 1'b0);
      do_access("post_rst", 0, 1'b1, 12'h0AA, 16'h5555, 1, 16'hA0A0);

      // Random transactions.
      for (int n = 0; n < 40; n++) begin
         op     = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
         ack_at = ($urandom_range(0, 4) == 0) ? int'(TO) + 3 : int'($urandom_range(0, TO - 1));
         do_access($sformatf("rnd%0d", n), op, 1'($urandom), AW'($urandom), DW'($urandom),
                   ack_at, DW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
